// File: rtl/hs_pkg.sv
// Shared handshake state types used by the receive-side blocks.
package hs_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_ACK  = 2'd2
    } hs_state_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rx_word_packer_if.sv
// Beat input, packed-word output and status signals of the receive word packer.
interface rx_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int NUM   = 4
);
    localparam int CW = $clog2(NUM);

    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 flush;
    logic [WIDTH*NUM-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overflow;
    logic                 ovf_clr;
    logic [CW-1:0]        beat_cnt;

    modport master (
        input  in_data, in_valid, flush, out_ready, ovf_clr,
        output out_data, out_valid, overflow, beat_cnt
    );

    modport slave (
        output in_data, in_valid, flush, out_ready, ovf_clr,
        input  out_data, out_valid, overflow, beat_cnt
    );

endinterface

// File: rtl/rx_word_packer.sv
// Packs NUM beats of WIDTH bits into one word; a single-entry output register
// with no input backpressure, so a completed word that cannot be stored is dropped.
module rx_word_packer
    import hs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM   = 4
) (
    input  logic              rx_clk,
    input  logic              rx_rst_b,
    rx_word_packer_if.master  bus
);

    localparam int CW = $clog2(NUM);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM - 1);

    logic [WIDTH*NUM-1:0] asm_q, asm_d;
    logic [WIDTH*NUM-1:0] out_q, out_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    out_state_e           state_q, state_d;
    logic                 ovf_q, ovf_d;

    logic                 accept_s;
    logic                 complete_s;
    logic                 handshake_s;
    logic                 drop_s;
    logic [WIDTH*NUM-1:0] word_s;

    // Beat acceptance and the assembled word including the lane being written now.
    always_comb begin
        accept_s    = bus.in_valid & ~bus.flush;
        complete_s  = accept_s & (cnt_q == LAST_BEAT);
        handshake_s = (state_q == OUT_FULL) & bus.out_ready;
        word_s      = asm_q;
        word_s[int'(cnt_q)*WIDTH +: WIDTH] = bus.in_data;
    end

    // Assembly register and beat counter next state.
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            cnt_d = {CW{1'b0}};
        end else if (accept_s) begin
            asm_d = word_s;
            if (complete_s) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output state machine: load, hold, drop and overflow decisions.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        drop_s  = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (complete_s) begin
                    state_d = OUT_FULL;
                    out_d   = word_s;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (complete_s && handshake_s) begin
                    state_d = OUT_FULL;
                    out_d   = word_s;
                end else if (complete_s) begin
                    state_d = OUT_FULL;
                    drop_s  = 1'b1;
                end else if (handshake_s) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
        // A new drop outranks a clear arriving in the same cycle.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge rx_clk or negedge rx_rst_b) begin
        if (!rx_rst_b) begin
            asm_q   <= {(WIDTH*NUM){1'b0}};
            out_q   <= {(WIDTH*NUM){1'b0}};
            cnt_q   <= {CW{1'b0}};
            state_q <= OUT_EMPTY;
            ovf_q   <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = (state_q == OUT_FULL);
    assign bus.overflow  = ovf_q;
    assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed bench for rx_word_packer: a cycle table plus hand-written reset sequences.
module tb_rx_word_packer;

    localparam int WIDTH = 8;
    localparam int NUM   = 4;

    logic rx_clk;
    logic rx_rst_b;
    int   errors;
    int   checks;

    rx_word_packer_if #(.WIDTH(WIDTH), .NUM(NUM)) bus ();

    rx_word_packer #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .rx_clk   (rx_clk),
        .rx_rst_b (rx_rst_b),
        .bus      (bus.master)
    );

    initial begin
        rx_clk = 1'b0;
        forever #5 rx_clk = ~rx_clk;
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fl;
        logic        rdy;
        logic        clr;
        logic        eov;
        logic [31:0] eod;
        logic        eovf;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, input logic [7:0] d, input logic fl, input logic rdy,
                       input logic clr, input logic eov, input logic [31:0] eod,
                       input logic eovf, input logic [1:0] ecnt);
        vec_t t;
        t.v = v; t.d = d; t.fl = fl; t.rdy = rdy; t.clr = clr;
        t.eov = eov; t.eod = eod; t.eovf = eovf; t.ecnt = ecnt;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic eov, input logic [31:0] eod,
                             input logic eovf, input logic [1:0] ecnt);
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, eov});
        check({tag, ".out_data"},  bus.out_data, eod);
        check({tag, ".overflow"},  {31'd0, bus.overflow}, {31'd0, eovf});
        check({tag, ".beat_cnt"},  {30'd0, bus.beat_cnt}, {30'd0, ecnt});
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic fl,
                         input logic rdy, input logic clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        @(posedge rx_clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rx_rst_b      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;

        // Basic packing, single-cycle out_valid.
        add(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        add(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd2);
        add(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd3);
        add(1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4433_2211, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4433_2211, 1'b0, 2'd0);
        // Stall: second word dropped, overflow set.
        add(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4433_2211, 1'b0, 2'd1);
        add(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4433_2211, 1'b0, 2'd2);
        add(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4433_2211, 1'b0, 2'd3);
        add(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd0);
        add(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd1);
        add(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd2);
        add(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd3);
        add(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b1, 2'd0);
        // ovf_clr alone, then coincident with a new drop.
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0403_0201, 1'b0, 2'd0);
        add(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd1);
        add(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd2);
        add(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd3);
        add(1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0403_0201, 1'b1, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0403_0201, 1'b1, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0403_0201, 1'b0, 2'd0);
        // Handshake coincident with completing beat reloads without overflow.
        add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0403_0201, 1'b0, 2'd1);
        add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0403_0201, 1'b0, 2'd2);
        add(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0403_0201, 1'b0, 2'd3);
        add(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA4A3_A2A1, 1'b0, 2'd0);
        add(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA4A3_A2A1, 1'b0, 2'd1);
        add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA4A3_A2A1, 1'b0, 2'd2);
        add(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA4A3_A2A1, 1'b0, 2'd3);
        add(1'b1, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB4B3_B2B1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd0);
        // Flush discards the partial word and the beat in the flush cycle.
        add(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd1);
        add(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd2);
        add(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd0);
        add(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd1);
        add(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd2);
        add(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB4B3_B2B1, 1'b0, 2'd3);
        add(1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0403_0201, 1'b0, 2'd0);

        // Reset state.
        repeat (2) @(posedge rx_clk);
        #1;
        check_all("reset", 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        @(negedge rx_clk);
        rx_rst_b = 1'b1;
        @(posedge rx_clk);
        #1;

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].d, vq[i].fl, vq[i].rdy, vq[i].clr);
            check_all($sformatf("vec%0d", i), vq[i].eov, vq[i].eod, vq[i].eovf, vq[i].ecnt);
        end

        // Reset mid-word while a word is held and overflow is set.
        drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
        check_all("pre_rst_word", 1'b1, 32'hC4C3_C2C1, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0, 1'b0);
        end
        check_all("pre_rst_ovf", 1'b1, 32'hC4C3_C2C1, 1'b1, 2'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'hE0 + 8'(k), 1'b0, 1'b0, 1'b0);
        end
        check_all("pre_rst_3beats", 1'b1, 32'hC4C3_C2C1, 1'b1, 2'd3);
        bus.in_valid = 1'b0;
        #2;
        rx_rst_b = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        @(negedge rx_clk);
        rx_rst_b = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_idle", 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        drive(1'b1, 8'hF1, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_b1", 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        drive(1'b1, 8'hF2, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_b2", 1'b0, 32'h0000_0000, 1'b0, 2'd2);
        drive(1'b1, 8'hF3, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_b3", 1'b0, 32'h0000_0000, 1'b0, 2'd3);
        drive(1'b1, 8'hF4, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_word", 1'b1, 32'hF4F3_F2F1, 1'b0, 2'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_done", 1'b0, 32'hF4F3_F2F1, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
